// File: rtl/ex_stage_pipelined.sv
// Execute stage: single-cycle ALU/AGU/branch ops plus a multi-cycle
// MAC with internal accumulator, valid/ready handshake in and out.
// Ports: clk, rst (sync, active high), flush, in_valid/in_ready,
//   Inst_In, Inst_Type_In, Operand_A/B_val_In, Immx_Data_In,
//   out_valid/out_ready, Result_Out, isBranchTaken_Out,
//   Operand_B_Out, Inst_Out, Inst_Type_Out.
module ex_stage_pipelined #(
  parameter int XLEN       = 32,
  parameter int MAC_CYCLES = 3,
  parameter int ACC_W      = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     Inst_In,
  input  logic [4:0]      Inst_Type_In,
  input  logic [XLEN-1:0] Operand_A_val_In,
  input  logic [XLEN-1:0] Operand_B_val_In,
  input  logic [XLEN-1:0] Immx_Data_In,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] Result_Out,
  output logic            isBranchTaken_Out,
  output logic [XLEN-1:0] Operand_B_Out,
  output logic [31:0]     Inst_Out,
  output logic [4:0]      Inst_Type_Out
);

  localparam logic [4:0] T_IMM = 5'b00100;
  localparam logic [4:0] T_RR  = 5'b01100;
  localparam logic [4:0] T_LD  = 5'b00000;
  localparam logic [4:0] T_ST  = 5'b01000;
  localparam logic [4:0] T_BR  = 5'b11000;
  localparam logic [4:0] T_MAC = 5'b11111;
  localparam int SHW = $clog2(XLEN);
  localparam int CW  = (MAC_CYCLES > 1) ? $clog2(MAC_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(MAC_CYCLES - 1);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic [ACC_W-1:0]  r_acc;
  logic [XLEN-1:0]   r_mac_a;
  logic [XLEN-1:0]   r_mac_b;
  logic [2:0]        r_mac_f3;
  logic [31:0]       r_mac_inst;
  logic              r_valid;
  logic [XLEN-1:0]   r_res;
  logic              r_taken;
  logic [XLEN-1:0]   r_opb;
  logic [31:0]       r_inst;
  logic [4:0]        r_type;

  logic              w_accept;
  logic              w_is_mac;
  logic [6:0]        w_f7;
  logic [2:0]        w_f3;
  logic [SHW-1:0]    w_sh;
  logic [XLEN-1:0]   w_res;
  logic              w_taken;
  logic [XLEN-1:0]   w_opb;
  logic              w_cond;
  logic              w_busy;
  logic [XLEN-1:0]   w_ma;
  logic [XLEN-1:0]   w_mb;
  logic [2:0]        w_mf3;
  logic [31:0]       w_minst;
  logic signed [2*XLEN-1:0] w_prod;
  logic [ACC_W-1:0]  w_prod_acc;
  logic [ACC_W-1:0]  w_sum;
  logic [ACC_W-1:0]  w_acc_nxt;
  logic [XLEN-1:0]   w_mres;

  assign in_ready = !flush && (r_state == S_IDLE) &&
                    (!r_valid || out_ready);
  assign w_accept = in_valid && in_ready;
  assign w_is_mac = (Inst_Type_In == T_MAC);
  assign w_f7 = Inst_In[31:25];
  assign w_f3 = Inst_In[14:12];
  assign w_sh = Operand_B_val_In[SHW-1:0];

  always_comb begin
    w_cond = 1'b0;
    case (w_f3)
      3'b000: w_cond = (Operand_A_val_In == Operand_B_val_In);
      3'b001: w_cond = (Operand_A_val_In != Operand_B_val_In);
      3'b100: w_cond = ($signed(Operand_A_val_In) <
                        $signed(Operand_B_val_In));
      3'b101: w_cond = ($signed(Operand_A_val_In) >=
                        $signed(Operand_B_val_In));
      default: w_cond = 1'b0;
    endcase
  end

  always_comb begin
    w_res   = '0;
    w_taken = 1'b0;
    w_opb   = '0;
    unique case (1'b1)
      (Inst_Type_In == T_IMM),
      (Inst_Type_In == T_LD):
        w_res = Operand_A_val_In + Immx_Data_In;
      (Inst_Type_In == T_ST): begin
        w_res = Operand_A_val_In + Immx_Data_In;
        w_opb = Operand_B_val_In;
      end
      (Inst_Type_In == T_RR): begin
        case ({w_f7, w_f3}) inside
          10'b0000000_000: w_res = Operand_A_val_In + Operand_B_val_In;
          10'b0100000_000: w_res = Operand_A_val_In - Operand_B_val_In;
          10'b???????_001: w_res = Operand_A_val_In << w_sh;
          10'b0000000_010:
            w_res = {{(XLEN-1){1'b0}},
                     $signed(Operand_A_val_In) <
                     $signed(Operand_B_val_In)};
          10'b???????_100: w_res = Operand_A_val_In ^ Operand_B_val_In;
          10'b0000000_101: w_res = Operand_A_val_In >> w_sh;
          10'b0100000_101:
            w_res = $signed(Operand_A_val_In) >>> w_sh;
          10'b???????_110: w_res = Operand_A_val_In | Operand_B_val_In;
          10'b???????_111: w_res = Operand_A_val_In & Operand_B_val_In;
          default: w_res = '0;
        endcase
      end
      (Inst_Type_In == T_BR): begin
        if (w_cond) begin
          w_res   = Immx_Data_In;
          w_taken = 1'b1;
        end
      end
      default: w_res = '0;
    endcase
  end

  // MAC operands come straight from the inputs when it completes in
  // the accept cycle, otherwise from the copy latched at accept.
  assign w_busy  = (r_state == S_BUSY);
  assign w_ma    = w_busy ? r_mac_a    : Operand_A_val_In;
  assign w_mb    = w_busy ? r_mac_b    : Operand_B_val_In;
  assign w_mf3   = w_busy ? r_mac_f3   : w_f3;
  assign w_minst = w_busy ? r_mac_inst : Inst_In;
  assign w_prod  = $signed(w_ma) * $signed(w_mb);

  if (ACC_W > 2*XLEN) begin : g_ext
    assign w_prod_acc = {{(ACC_W-2*XLEN){w_prod[2*XLEN-1]}}, w_prod};
  end else begin : g_trunc
    assign w_prod_acc = w_prod[ACC_W-1:0];
  end

  assign w_sum = r_acc + w_prod_acc;

  always_comb begin
    w_acc_nxt = r_acc;
    w_mres    = '0;
    case (w_mf3)
      3'b000: begin
        w_acc_nxt = w_prod_acc;
        w_mres    = w_prod_acc[XLEN-1:0];
      end
      3'b001: begin
        w_acc_nxt = w_sum;
        w_mres    = w_sum[XLEN-1:0];
      end
      3'b010: w_acc_nxt = '0;
      default: w_acc_nxt = r_acc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_mac_a    <= '0;
      r_mac_b    <= '0;
      r_mac_f3   <= '0;
      r_mac_inst <= '0;
      r_valid    <= 1'b0;
      r_res      <= '0;
      r_taken    <= 1'b0;
      r_opb      <= '0;
      r_inst     <= '0;
      r_type     <= '0;
    end else if (flush) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_valid <= 1'b0;
    end else begin
      if (r_valid && out_ready) r_valid <= 1'b0;
      if (w_accept && w_is_mac && MAC_CYCLES > 1) begin
        r_state    <= S_BUSY;
        r_cnt      <= CNT_INIT;
        r_mac_a    <= Operand_A_val_In;
        r_mac_b    <= Operand_B_val_In;
        r_mac_f3   <= w_f3;
        r_mac_inst <= Inst_In;
      end else if ((w_accept && w_is_mac) ||
                   (w_busy && r_cnt == '0)) begin
        r_state <= S_IDLE;
        r_acc   <= w_acc_nxt;
        r_valid <= 1'b1;
        r_res   <= w_mres;
        r_taken <= 1'b0;
        r_opb   <= '0;
        r_inst  <= w_minst;
        r_type  <= T_MAC;
      end else if (w_accept) begin
        r_valid <= 1'b1;
        r_res   <= w_res;
        r_taken <= w_taken;
        r_opb   <= w_opb;
        r_inst  <= Inst_In;
        r_type  <= Inst_Type_In;
      end else if (w_busy) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign out_valid         = r_valid;
  assign Result_Out        = r_res;
  assign isBranchTaken_Out = r_taken;
  assign Operand_B_Out     = r_opb;
  assign Inst_Out          = r_inst;
  assign Inst_Type_Out     = r_type;

endmodule

// File: tb/tb_ex_stage_pipelined.sv
// Directed scoreboard bench for ex_stage_pipelined.
// Expected results queued at accept, compared on output handshake.
module tb_ex_stage_pipelined;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] Inst_In;
  logic [4:0]  Inst_Type_In;
  logic [31:0] Operand_A_val_In;
  logic [31:0] Operand_B_val_In;
  logic [31:0] Immx_Data_In;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Result_Out;
  logic        isBranchTaken_Out;
  logic [31:0] Operand_B_Out;
  logic [31:0] Inst_Out;
  logic [4:0]  Inst_Type_Out;

  localparam logic [4:0] T_IMM = 5'b00100;
  localparam logic [4:0] T_RR  = 5'b01100;
  localparam logic [4:0] T_ST  = 5'b01000;
  localparam logic [4:0] T_BR  = 5'b11000;
  localparam logic [4:0] T_MAC = 5'b11111;

  typedef struct {
    logic [31:0] r;
    logic        t;
    logic [31:0] o;
    logic [31:0] i;
    logic [4:0]  ty;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;

  ex_stage_pipelined #(.XLEN(32), .MAC_CYCLES(3), .ACC_W(64)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .Inst_In(Inst_In), .Inst_Type_In(Inst_Type_In),
    .Operand_A_val_In(Operand_A_val_In),
    .Operand_B_val_In(Operand_B_val_In),
    .Immx_Data_In(Immx_Data_In),
    .out_valid(out_valid), .out_ready(out_ready),
    .Result_Out(Result_Out),
    .isBranchTaken_Out(isBranchTaken_Out),
    .Operand_B_Out(Operand_B_Out),
    .Inst_Out(Inst_Out), .Inst_Type_Out(Inst_Type_Out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] f7,
                                     input logic [2:0] f3);
    return {f7, 10'h0, f3, 12'h0};
  endfunction

  // Output handshake monitor: pop and compare on each transfer.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_out", 64'(out_valid), 64'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("result", 64'(Result_Out), 64'(e.r));
        chk("taken", 64'(isBranchTaken_Out), 64'(e.t));
        chk("opb", 64'(Operand_B_Out), 64'(e.o));
        chk("inst", 64'(Inst_Out), 64'(e.i));
        chk("type", 64'(Inst_Type_Out), 64'(e.ty));
      end
    end
  end

  task automatic send(input logic [4:0] ty, input logic [31:0] inst,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] imm, input logic push,
                      input logic [31:0] er, input logic et,
                      input logic [31:0] eo, output int waits);
    exp_t e;
    in_valid = 1'b1;
    Inst_Type_In = ty;
    Inst_In = inst;
    Operand_A_val_In = a;
    Operand_B_val_In = b;
    Immx_Data_In = imm;
    waits = 0;
    @(negedge clk);
    while (!in_ready && waits < 20) begin
      waits++;
      @(negedge clk);
    end
    if (!in_ready) chk("accept_timeout", 64'd0, 64'd1);
    if (push) begin
      e.r = er; e.t = et; e.o = eo; e.i = inst; e.ty = ty;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int w;
    int n;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    Inst_In = '0; Inst_Type_In = '0;
    Operand_A_val_In = '0; Operand_B_val_In = '0; Immx_Data_In = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(Result_Out), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);

    send(T_IMM, mk(7'h0, 3'b000), 32'd5, 32'd0, 32'hFFFF_FFFD,
         1'b1, 32'd2, 1'b0, 32'd0, w);
    chk("imm_latency", 64'(out_valid), 64'd1);
    send(T_RR, mk(7'b0100000, 3'b101), 32'h8000_0000, 32'd4, 32'd0,
         1'b1, 32'hF800_0000, 1'b0, 32'd0, w);
    send(T_RR, mk(7'b0000000, 3'b010), 32'hFFFF_FFFF, 32'd1, 32'd0,
         1'b1, 32'd1, 1'b0, 32'd0, w);
    send(T_RR, mk(7'b0100000, 3'b000), 32'd3, 32'd5, 32'd0,
         1'b1, 32'hFFFF_FFFE, 1'b0, 32'd0, w);
    send(T_RR, mk(7'b0100000, 3'b010), 32'd3, 32'd5, 32'd0,
         1'b1, 32'd0, 1'b0, 32'd0, w);
    send(T_BR, mk(7'h0, 3'b001), 32'd7, 32'd7, 32'h40,
         1'b1, 32'd0, 1'b0, 32'd0, w);
    send(T_BR, mk(7'h0, 3'b000), 32'd7, 32'd7, 32'h40,
         1'b1, 32'h40, 1'b1, 32'd0, w);
    send(T_BR, mk(7'h0, 3'b100), 32'hFFFF_FFFF, 32'd1, 32'h20,
         1'b1, 32'h20, 1'b1, 32'd0, w);
    send(T_ST, mk(7'h0, 3'b010), 32'h100, 32'hDEAD, 32'd8,
         1'b1, 32'h108, 1'b0, 32'hDEAD, w);
    send(5'b10101, mk(7'h0, 3'b000), 32'd9, 32'd9, 32'd9,
         1'b1, 32'd0, 1'b0, 32'd0, w);
    chk("throughput_waits", 64'(w), 64'd0);

    send(T_MAC, mk(7'h0, 3'b000), 32'd3, 32'd4, 32'd0,
         1'b1, 32'd12, 1'b0, 32'd0, w);
    chk("mac_busy_ready", 64'(in_ready), 64'd0);
    wait_valid(n);
    chk("mac1_latency", 64'(n), 64'd3);
    idle(1);
    send(T_MAC, mk(7'h0, 3'b001), 32'hFFFF_FFFE, 32'd5, 32'd0,
         1'b1, 32'd2, 1'b0, 32'd0, w);
    chk("mac_busy_ready2", 64'(in_ready), 64'd0);
    wait_valid(n);
    chk("mac2_latency", 64'(n), 64'd3);
    idle(1);

    out_ready = 1'b0;
    send(T_IMM, mk(7'h0, 3'b000), 32'd1, 32'd0, 32'd1,
         1'b1, 32'd2, 1'b0, 32'd0, w);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_result", 64'(Result_Out), 64'd2);
      chk("bp_ready", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send(T_RR, mk(7'h0, 3'b000), 32'd7, 32'd8, 32'd0,
         1'b1, 32'd15, 1'b0, 32'd0, w);
    chk("bp_release_waits", 64'(w), 64'd0);
    chk("bp_new_valid", 64'(out_valid), 64'd1);
    idle(1);

    send(T_MAC, mk(7'h0, 3'b001), 32'd10, 32'd10, 32'd0,
         1'b0, 32'd0, 1'b0, 32'd0, w);
    @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    chk("flush_ready_low", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1 flush = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("flush_no_valid", 64'(out_valid), 64'd0);
      @(posedge clk);
      #1;
    end
    chk("flush_idle_ready", 64'(in_ready), 64'd1);
    send(T_MAC, mk(7'h0, 3'b001), 32'd1, 32'd1, 32'd0,
         1'b1, 32'd3, 1'b0, 32'd0, w);
    wait_valid(n);
    idle(1);

    flush = 1'b1;
    in_valid = 1'b1;
    Inst_Type_In = T_IMM;
    Inst_In = mk(7'h0, 3'b000);
    Operand_A_val_In = 32'd1;
    Immx_Data_In = 32'd1;
    @(negedge clk);
    chk("flush_drop_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1 flush = 1'b0; in_valid = 1'b0;
    chk("flush_drop_valid", 64'(out_valid), 64'd0);

    send(T_MAC, mk(7'h0, 3'b010), 32'd4, 32'd4, 32'd0,
         1'b1, 32'd0, 1'b0, 32'd0, w);
    wait_valid(n);
    idle(1);
    send(T_MAC, mk(7'h0, 3'b001), 32'd2, 32'd3, 32'd0,
         1'b1, 32'd6, 1'b0, 32'd0, w);
    wait_valid(n);
    idle(1);

    send(T_MAC, mk(7'h0, 3'b000), 32'd5, 32'd5, 32'd0,
         1'b0, 32'd0, 1'b0, 32'd0, w);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_mid_mac_valid", 64'(out_valid), 64'd0);
    chk("rst_mid_mac_ready", 64'(in_ready), 64'd1);
    send(T_MAC, mk(7'h0, 3'b001), 32'd1, 32'd1, 32'd0,
         1'b1, 32'd1, 1'b0, 32'd0, w);
    wait_valid(n);
    chk("mac_after_rst_latency", 64'(n), 64'd3);

    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    idle(2);
    chk("queue_drained", 64'(q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
